// File: rtl/tlb_address_translator_pkg.sv
// Shared types and field widths for the TLB address translator.
package tlb_pkg;

    localparam int PAGE_WIDTH   = 20;
    localparam int OFFSET_WIDTH = 12;
    localparam int FRAME_WIDTH  = 20;

    localparam logic [1:0] DIRECT_WINDOW_PREFIX = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [PAGE_WIDTH-1:0]  page;
        logic [FRAME_WIDTH-1:0] frame;
        logic                   writeable;
        logic                   valid;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_address_translator_if.sv
// Request/result and TLB-write bundle between the CPU/MMU side and the translator.
interface tlb_address_translator_if #(
    parameter int TLB_INDEX_WIDTH = 5
);
    logic                       translateRequest;
    logic [31:0]                virtualAddress;
    logic                       isWrite;
    logic                       userMode;
    logic                       tlbWriteEnable;
    logic [TLB_INDEX_WIDTH-1:0] tlbWriteIndex;
    logic [19:0]                tlbWritePage;
    logic [19:0]                tlbWriteFrame;
    logic                       tlbWriteWriteable;
    logic                       tlbWriteValid;
    logic                       busy;
    logic                       translateDone;
    logic [31:0]                physicalAddress;
    logic                       missFault;
    logic                       writeFault;
    logic                       privilegeFault;

    modport master (
        output translateRequest, virtualAddress, isWrite, userMode,
        output tlbWriteEnable, tlbWriteIndex, tlbWritePage, tlbWriteFrame,
        output tlbWriteWriteable, tlbWriteValid,
        input  busy, translateDone, physicalAddress,
        input  missFault, writeFault, privilegeFault
    );

    modport slave (
        input  translateRequest, virtualAddress, isWrite, userMode,
        input  tlbWriteEnable, tlbWriteIndex, tlbWritePage, tlbWriteFrame,
        input  tlbWriteWriteable, tlbWriteValid,
        output busy, translateDone, physicalAddress,
        output missFault, writeFault, privilegeFault
    );
endinterface

// File: rtl/tlb_address_translator_entry_array.sv
// TLB storage (module tlb_entry_array): one write port, asynchronous read ports.
// TLB_ADDRESS_TRANSLATOR_LAST_HIT_EN adds a second read port for the last-hit cache.
module tlb_entry_array
    import tlb_pkg::*;
#(
    parameter int TLB_ENTRIES     = 32,
    parameter int TLB_INDEX_WIDTH = 5
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic                       write_enable,
    input  logic [TLB_INDEX_WIDTH-1:0] write_index,
    input  tlb_entry_t                 write_entry,
    input  logic [TLB_INDEX_WIDTH-1:0] read_index,
    output tlb_entry_t                 read_entry
`ifdef TLB_ADDRESS_TRANSLATOR_LAST_HIT_EN
    ,
    input  logic [TLB_INDEX_WIDTH-1:0] cache_index,
    output tlb_entry_t                 cache_entry
`endif
);

    logic [PAGE_WIDTH-1:0]  page_mem  [TLB_ENTRIES];
    logic [FRAME_WIDTH-1:0] frame_mem [TLB_ENTRIES];
    logic [TLB_ENTRIES-1:0] writeable_mem;
    logic [TLB_ENTRIES-1:0] valid_reg;

    // Only the valid bits are reset; the payload is meaningless while invalid.
    always_ff @(posedge clock) begin
        if (write_enable) begin
            page_mem[write_index]      <= write_entry.page;
            frame_mem[write_index]     <= write_entry.frame;
            writeable_mem[write_index] <= write_entry.writeable;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            valid_reg <= '0;
        end else if (write_enable) begin
            valid_reg[write_index] <= write_entry.valid;
        end
    end

    assign read_entry = {page_mem[read_index], frame_mem[read_index],
                         writeable_mem[read_index], valid_reg[read_index]};

`ifdef TLB_ADDRESS_TRANSLATOR_LAST_HIT_EN
    assign cache_entry = {page_mem[cache_index], frame_mem[cache_index],
                          writeable_mem[cache_index], valid_reg[cache_index]};
`endif

endmodule

// File: rtl/tlb_address_translator.sv
// Sequential-search TLB translator with a direct-mapped kernel window bypass.
// Optional last-hit cache: define TLB_ADDRESS_TRANSLATOR_LAST_HIT_EN.
module tlb_address_translator
    import tlb_pkg::*;
#(
    parameter int TLB_ENTRIES     = 32,
    parameter int TLB_INDEX_WIDTH = 5
) (
    input  logic                     clock,
    input  logic                     resetN,
    tlb_address_translator_if.slave  bus
);

    localparam logic [TLB_INDEX_WIDTH-1:0] LAST_INDEX = TLB_INDEX_WIDTH'(TLB_ENTRIES - 1);

    state_t                     state_reg, state_next;
    logic [TLB_INDEX_WIDTH-1:0] index_reg, index_next;
    logic [31:0]                va_reg, va_next;
    logic                       is_write_reg, is_write_next;
    logic [31:0]                pa_reg, pa_next;
    logic                       miss_reg, miss_next;
    logic                       wf_reg, wf_next;
    logic                       pf_reg, pf_next;

    tlb_entry_t write_entry;
    tlb_entry_t read_entry;
    logic       entry_match;

`ifdef TLB_ADDRESS_TRANSLATOR_LAST_HIT_EN
    logic                       cache_valid_reg, cache_valid_next;
    logic [TLB_INDEX_WIDTH-1:0] cache_index_reg, cache_index_next;
    tlb_entry_t                 cache_entry;
    logic                       cache_hit;
`endif

    assign write_entry = '{page:      bus.tlbWritePage,
                           frame:     bus.tlbWriteFrame,
                           writeable: bus.tlbWriteWriteable,
                           valid:     bus.tlbWriteValid};

    tlb_entry_array #(
        .TLB_ENTRIES     (TLB_ENTRIES),
        .TLB_INDEX_WIDTH (TLB_INDEX_WIDTH)
    ) u_entries (
        .clock        (clock),
        .resetN       (resetN),
        .write_enable (bus.tlbWriteEnable),
        .write_index  (bus.tlbWriteIndex),
        .write_entry  (write_entry),
        .read_index   (index_reg),
        .read_entry   (read_entry)
`ifdef TLB_ADDRESS_TRANSLATOR_LAST_HIT_EN
        ,
        .cache_index  (cache_index_reg),
        .cache_entry  (cache_entry)
`endif
    );

    assign entry_match = read_entry.valid &&
                         (read_entry.page == va_reg[31:OFFSET_WIDTH]);

`ifdef TLB_ADDRESS_TRANSLATOR_LAST_HIT_EN
    // A write landing on the cached slot this edge makes the cached contents stale.
    assign cache_hit = cache_valid_reg && cache_entry.valid &&
                       (cache_entry.page == bus.virtualAddress[31:OFFSET_WIDTH]) &&
                       !(bus.tlbWriteEnable && (bus.tlbWriteIndex == cache_index_reg));
`endif

    always_comb begin
        state_next    = state_reg;
        index_next    = index_reg;
        va_next       = va_reg;
        is_write_next = is_write_reg;
        pa_next       = pa_reg;
        miss_next     = miss_reg;
        wf_next       = wf_reg;
        pf_next       = pf_reg;
`ifdef TLB_ADDRESS_TRANSLATOR_LAST_HIT_EN
        cache_valid_next = cache_valid_reg;
        cache_index_next = cache_index_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.translateRequest) begin
                    va_next       = bus.virtualAddress;
                    is_write_next = bus.isWrite;
                    index_next    = '0;
                    miss_next     = 1'b0;
                    wf_next       = 1'b0;
                    pf_next       = 1'b0;
                    if (bus.userMode && bus.virtualAddress[31]) begin
                        pf_next    = 1'b1;
                        pa_next    = '0;
                        state_next = DONE;
                    end else if (!bus.userMode &&
                                 (bus.virtualAddress[31:30] == DIRECT_WINDOW_PREFIX)) begin
                        pa_next    = {2'b00, bus.virtualAddress[29:0]};
                        state_next = DONE;
`ifdef TLB_ADDRESS_TRANSLATOR_LAST_HIT_EN
                    end else if (cache_hit) begin
                        pa_next    = {cache_entry.frame, bus.virtualAddress[OFFSET_WIDTH-1:0]};
                        wf_next    = bus.isWrite & ~cache_entry.writeable;
                        state_next = DONE;
`endif
                    end else begin
                        state_next = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (entry_match) begin
                    pa_next    = {read_entry.frame, va_reg[OFFSET_WIDTH-1:0]};
                    wf_next    = is_write_reg & ~read_entry.writeable;
                    state_next = DONE;
`ifdef TLB_ADDRESS_TRANSLATOR_LAST_HIT_EN
                    cache_valid_next = 1'b1;
                    cache_index_next = index_reg;
`endif
                end else if (index_reg == LAST_INDEX) begin
                    miss_next  = 1'b1;
                    pa_next    = '0;
                    state_next = DONE;
                end else begin
                    index_next = index_reg + TLB_INDEX_WIDTH'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
`ifdef TLB_ADDRESS_TRANSLATOR_LAST_HIT_EN
        if (bus.tlbWriteEnable && (bus.tlbWriteIndex == cache_index_next)) begin
            cache_valid_next = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_reg    <= IDLE;
            index_reg    <= '0;
            va_reg       <= '0;
            is_write_reg <= 1'b0;
            pa_reg       <= '0;
            miss_reg     <= 1'b0;
            wf_reg       <= 1'b0;
            pf_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            index_reg    <= index_next;
            va_reg       <= va_next;
            is_write_reg <= is_write_next;
            pa_reg       <= pa_next;
            miss_reg     <= miss_next;
            wf_reg       <= wf_next;
            pf_reg       <= pf_next;
        end
    end

`ifdef TLB_ADDRESS_TRANSLATOR_LAST_HIT_EN
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cache_valid_reg <= 1'b0;
            cache_index_reg <= '0;
        end else begin
            cache_valid_reg <= cache_valid_next;
            cache_index_reg <= cache_index_next;
        end
    end
`endif

    assign bus.busy            = (state_reg == SEARCH);
    assign bus.translateDone   = (state_reg == DONE);
    assign bus.physicalAddress = pa_reg;
    assign bus.missFault       = miss_reg;
    assign bus.writeFault      = wf_reg;
    assign bus.privilegeFault  = pf_reg;

endmodule

// File: tb/tb_tlb_address_translator.sv
// Table-driven bench for tlb_address_translator with a done-time scoreboard.
// Honours TLB_ADDRESS_TRANSLATOR_LAST_HIT_EN for the expected latencies.
module tb_tlb_address_translator;

`ifdef TLB_ADDRESS_TRANSLATOR_LAST_HIT_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    int   cyc    = 0;
    int   tests  = 0;
    int   fails  = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    tlb_address_translator_if #(.TLB_INDEX_WIDTH(5)) bus ();

    tlb_address_translator #(
        .TLB_ENTRIES     (32),
        .TLB_INDEX_WIDTH (5)
    ) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    // lat = edges from the accepting edge to the edge that raises translateDone
    typedef struct {
        bit        do_write;
        bit [4:0]  widx;
        bit [19:0] wpage;
        bit [19:0] wframe;
        bit        ww;
        bit        wv;
        bit [31:0] va;
        bit        wr;
        bit        user;
        int        lat_nc;
        int        lat_c;
        bit [31:0] pa;
        bit        miss;
        bit        wf;
        bit        pf;
    } vec_t;

    typedef struct {
        bit [31:0] pa;
        bit        miss;
        bit        wf;
        bit        pf;
        int        done_cyc;
        int        id;
    } exp_t;

    vec_t vecs [12];
    exp_t sb [$];

    task automatic check(input string name, input int id,
                         input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s id=%0d: got %h, want %h", name, id, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (resetN && bus.translateDone) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("physicalAddress", e.id, bus.physicalAddress, e.pa);
                check("missFault", e.id, 32'(bus.missFault), 32'(e.miss));
                check("writeFault", e.id, 32'(bus.writeFault), 32'(e.wf));
                check("privilegeFault", e.id, 32'(bus.privilegeFault), 32'(e.pf));
                check("busy_in_done", e.id, 32'(bus.busy), 32'd0);
                check("done_cycle", e.id, 32'(cyc), 32'(e.done_cyc));
                $display("[TB] txn %0d done at cycle %0d pa=%h miss=%0b wf=%0b pf=%0b",
                         e.id, cyc, bus.physicalAddress, bus.missFault,
                         bus.writeFault, bus.privilegeFault);
            end
        end
    end

    // Called at a negedge where the request is being driven; E0 is the next posedge.
    task automatic push_expect(input int lat, input bit [31:0] pa, input bit miss,
                               input bit wf, input bit pf, input int id);
        exp_t e;
        e.pa = pa; e.miss = miss; e.wf = wf; e.pf = pf;
        e.done_cyc = cyc + 1 + lat;
        e.id = id;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input int id);
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout id=%0d: got no done, want done within 80 cycles", id);
            sb.delete();
        end
    endtask

    task automatic tlb_write(input bit [4:0] idx, input bit [19:0] page,
                             input bit [19:0] frame, input bit w, input bit v);
        @(negedge clock);
        bus.tlbWriteEnable    = 1'b1;
        bus.tlbWriteIndex     = idx;
        bus.tlbWritePage      = page;
        bus.tlbWriteFrame     = frame;
        bus.tlbWriteWriteable = w;
        bus.tlbWriteValid     = v;
        @(negedge clock);
        bus.tlbWriteEnable    = 1'b0;
    endtask

    task automatic request(input bit [31:0] va, input bit wr, input bit user,
                           input int lat, input bit [31:0] pa, input bit miss,
                           input bit wf, input bit pf, input int id);
        @(negedge clock);
        bus.translateRequest = 1'b1;
        bus.virtualAddress   = va;
        bus.isWrite          = wr;
        bus.userMode         = user;
        push_expect(lat, pa, miss, wf, pf, id);
        @(negedge clock);
        bus.translateRequest = 1'b0;
        #1;
        wait_idle(id);
    endtask

    initial begin
        //        wr  idx    page       frame      w  v   va            wr user nc  c   pa            m  wf pf
        vecs[0]  = '{0, 5'd0,  20'h0,     20'h0,     0, 0, 32'hC0001234, 0, 0,  0,  0, 32'h00001234, 0, 0, 0};
        vecs[1]  = '{0, 5'd0,  20'h0,     20'h0,     0, 0, 32'h80000000, 0, 1,  0,  0, 32'h00000000, 0, 0, 1};
        vecs[2]  = '{1, 5'd5,  20'h00012, 20'h000AB, 1, 1, 32'h00012345, 0, 0,  6,  6, 32'h000AB345, 0, 0, 0};
        vecs[3]  = '{1, 5'd3,  20'h00400, 20'h00055, 0, 1, 32'h00400010, 1, 0,  4,  4, 32'h00055010, 0, 1, 0};
        vecs[4]  = '{0, 5'd0,  20'h0,     20'h0,     0, 0, 32'h00400ABC, 0, 0,  4,  0, 32'h00055ABC, 0, 0, 0};
        vecs[5]  = '{0, 5'd0,  20'h0,     20'h0,     0, 0, 32'h00012FFF, 0, 1,  6,  6, 32'h000ABFFF, 0, 0, 0};
        vecs[6]  = '{0, 5'd0,  20'h0,     20'h0,     0, 0, 32'h00012000, 1, 0,  6,  0, 32'h000AB000, 0, 0, 0};
        vecs[7]  = '{0, 5'd0,  20'h0,     20'h0,     0, 0, 32'h80000000, 0, 0, 32, 32, 32'h00000000, 1, 0, 0};
        vecs[8]  = '{0, 5'd0,  20'h0,     20'h0,     0, 0, 32'hC0000000, 0, 1,  0,  0, 32'h00000000, 0, 0, 1};
        vecs[9]  = '{0, 5'd0,  20'h0,     20'h0,     0, 0, 32'hFFFFFFFF, 1, 0,  0,  0, 32'h3FFFFFFF, 0, 0, 0};
        vecs[10] = '{1, 5'd5,  20'h00012, 20'h000AB, 1, 0, 32'h00012345, 0, 0, 32, 32, 32'h00000000, 1, 0, 0};
        vecs[11] = '{1, 5'd31, 20'h00031, 20'hABCDE, 1, 1, 32'h00031FED, 0, 0, 32, 32, 32'hABCDEFED, 0, 0, 0};

        bus.translateRequest  = 1'b0;
        bus.virtualAddress    = '0;
        bus.isWrite           = 1'b0;
        bus.userMode          = 1'b0;
        bus.tlbWriteEnable    = 1'b0;
        bus.tlbWriteIndex     = '0;
        bus.tlbWritePage      = '0;
        bus.tlbWriteFrame     = '0;
        bus.tlbWriteWriteable = 1'b0;
        bus.tlbWriteValid     = 1'b0;

        repeat (3) @(negedge clock);
        check("reset_busy", 0, 32'(bus.busy), 32'd0);
        check("reset_done", 0, 32'(bus.translateDone), 32'd0);
        check("reset_pa", 0, bus.physicalAddress, 32'd0);
        check("reset_faults", 0,
              32'({bus.missFault, bus.writeFault, bus.privilegeFault}), 32'd0);
        resetN = 1'b1;

        // Empty TLB miss; a second request raised mid-search must be ignored.
        @(negedge clock);
        bus.translateRequest = 1'b1;
        bus.virtualAddress   = 32'h00001000;
        push_expect(32, 32'h0, 1'b1, 1'b0, 1'b0, 100);
        @(negedge clock);
        bus.translateRequest = 1'b0;
        repeat (3) @(negedge clock);
        bus.translateRequest = 1'b1;
        bus.virtualAddress   = 32'hC0001234;
        #1;
        check("busy_during_search", 100, 32'(bus.busy), 32'd1);
        repeat (3) @(negedge clock);
        bus.translateRequest = 1'b0;
        bus.virtualAddress   = 32'h00001000;
        wait_idle(100);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_write)
                tlb_write(vecs[i].widx, vecs[i].wpage, vecs[i].wframe, vecs[i].ww, vecs[i].wv);
            request(vecs[i].va, vecs[i].wr, vecs[i].user,
                    CACHE_ON ? vecs[i].lat_c : vecs[i].lat_nc,
                    vecs[i].pa, vecs[i].miss, vecs[i].wf, vecs[i].pf, i);
        end

        // Duplicate pages: lowest index wins; a repeat may hit the last-hit cache.
        tlb_write(5'd2, 20'h00010, 20'h00111, 1'b1, 1'b1);
        tlb_write(5'd7, 20'h00010, 20'h00777, 1'b1, 1'b1);
        request(32'h00010ABC, 1'b0, 1'b0, 3, 32'h00111ABC, 1'b0, 1'b0, 1'b0, 200);
        request(32'h00010ABC, 1'b0, 1'b0, CACHE_ON ? 0 : 3, 32'h00111ABC,
                1'b0, 1'b0, 1'b0, 201);

        // TLB write on the accepting edge is seen by the entry-0 compare.
        @(negedge clock);
        bus.tlbWriteEnable    = 1'b1;
        bus.tlbWriteIndex     = 5'd0;
        bus.tlbWritePage      = 20'h00020;
        bus.tlbWriteFrame     = 20'h00222;
        bus.tlbWriteWriteable = 1'b1;
        bus.tlbWriteValid     = 1'b1;
        bus.translateRequest  = 1'b1;
        bus.virtualAddress    = 32'h00020000;
        bus.isWrite           = 1'b0;
        bus.userMode          = 1'b0;
        push_expect(1, 32'h00222000, 1'b0, 1'b0, 1'b0, 300);
        @(negedge clock);
        bus.tlbWriteEnable   = 1'b0;
        bus.translateRequest = 1'b0;
        #1;
        wait_idle(300);

        // Reset during a search: no done, outputs cleared, TLB invalidated.
        @(negedge clock);
        bus.translateRequest = 1'b1;
        bus.virtualAddress   = 32'h00777000;
        @(negedge clock);
        bus.translateRequest = 1'b0;
        repeat (4) @(negedge clock);
        resetN = 1'b0;
        #1;
        check("midreset_busy", 400, 32'(bus.busy), 32'd0);
        check("midreset_pa", 400, bus.physicalAddress, 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        request(32'h00031000, 1'b0, 1'b0, 32, 32'h0, 1'b1, 1'b0, 1'b0, 401);
        request(32'h00020000, 1'b0, 1'b0, 32, 32'h0, 1'b1, 1'b0, 1'b0, 402);

        repeat (5) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish before 200000");
        $fatal(1, "global timeout");
    end

endmodule
